conversor_adc: RTL

- SPI capture stage directly upstream of the DAC converter: programs the programmable preamp gain once after reset, then runs continuous conversions on the 14-bit dual-channel ADC.
- Each ADC frame is reduced to one 12-bit two's-complement sample (bit 0 = MSB/sign) and emitted with a one-cycle strobe, directly consumable as the DAC block's `datos` input.
- Shares the SPI bus (MOSI/SCK) with the DAC block.
- Paced by the same `clock_enable` tick used by the DAC block.

---
 rtl/conversor_adc_pkg.sv | 32 +++
 rtl/conversor_adc_generador_sck.sv | 54 +++++
 rtl/conversor_adc.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/conversor_adc_pkg.sv
// conversor_adc_pkg: state encoding, frame geometry and helpers shared by the
// ADC capture stage and its SCK generator.
package conversor_adc_pkg;

  typedef enum logic [1:0] {
    AMP_CFG = 2'd0,
    CONV    = 2'd1,
    READ    = 2'd2,
    PUBLISH = 2'd3
  } estado_t;

  localparam int BITS_TRAMA    = 34;
  localparam int INICIO_CANAL0 = 2;
  localparam int INICIO_CANAL1 = 18;
  localparam int BITS_MUESTRA  = 14;
  localparam int BITS_SALIDA   = 12;
  localparam int BITS_GANANCIA = 8;

  // Wide enough for the 34-bit frame index.
  localparam int BITS_CNT = 6;

  localparam logic [BITS_GANANCIA-1:0] GANANCIA_DEF = 8'h11;

  // The DAC block expects its sample with the sign in bit 0.
  function automatic logic [BITS_SALIDA-1:0] invertir_bits(input logic [BITS_SALIDA-1:0] v);
    logic [BITS_SALIDA-1:0] r;
    r = '0;
    for (int i = 0; i < BITS_SALIDA; i++) r[i] = v[BITS_SALIDA-1-i];
    return r;
  endfunction

endpackage

// File: rtl/conversor_adc_generador_sck.sv
// generador_sck: SCK phase flag, registered SCK, rise/fall tick strobes and
// bit counter. One bit = two enabled ticks; the counter advances on the fall.
module generador_sck
  import conversor_adc_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                enable,
  output logic                sck,
  output logic                subida,
  output logic                bajada,
  output logic [BITS_CNT-1:0] bit_cnt
);

  logic                fase_q, fase_d;
  logic                sck_q, sck_d;
  logic [BITS_CNT-1:0] cnt_q, cnt_d;

  // Clear has priority so the FSM can end a bit and restart in one tick.
  always_comb begin
    fase_d = fase_q;
    sck_d  = sck_q;
    cnt_d  = cnt_q;
    if (clear) begin
      fase_d = 1'b0;
      sck_d  = 1'b0;
      cnt_d  = '0;
    end else if (enable) begin
      fase_d = ~fase_q;
      sck_d  = ~fase_q;
      if (fase_q) cnt_d = cnt_q + 1'b1;
    end
  end

  // Phase, SCK and bit counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fase_q <= 1'b0;
      sck_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      fase_q <= fase_d;
      sck_q  <= sck_d;
      cnt_q  <= cnt_d;
    end
  end

  assign subida  = enable & ~fase_q;
  assign bajada  = enable & fase_q;
  assign sck     = sck_q;
  assign bit_cnt = cnt_q;

endmodule

// File: rtl/conversor_adc.sv
// conversor_adc: programs the preamp gain once after reset, then runs
// continuous conversions on the dual-channel ADC and publishes one 12-bit
// sample (sign in bit 0) per frame with a one-clock dato_valido strobe.
// Build option ADC_REDONDEO_EN: round half up with positive saturation
// instead of truncating the two LSBs.
//
// state   | meaning
// AMP_CFG | shift GANANCIA into the preamp, amp_cs low (once after reset)
// CONV    | ad_conv high for one bit period, SCK idle low
// READ    | 34 SCK cycles, selected channel shifted in on SCK rise
// PUBLISH | reduce sample, update datos, pulse dato_valido
module conversor_adc
  import conversor_adc_pkg::*;
#(
  parameter logic [BITS_GANANCIA-1:0] GANANCIA = GANANCIA_DEF,
  parameter int                       CANAL    = 0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clock_enable,
  input  logic                   spi_miso,
  output logic                   spi_mosi,
  output logic                   spi_sck,
  output logic                   amp_cs,
  output logic                   amp_shdn,
  output logic                   ad_conv,
  output logic [BITS_SALIDA-1:0] datos,
  output logic                   dato_valido
);

  localparam logic [BITS_CNT-1:0] INICIO =
    (CANAL == 0) ? BITS_CNT'(INICIO_CANAL0) : BITS_CNT'(INICIO_CANAL1);
  localparam logic [BITS_CNT-1:0] FIN        = INICIO + BITS_CNT'(BITS_MUESTRA);
  localparam logic [BITS_CNT-1:0] ULTIMO_BIT = BITS_CNT'(BITS_TRAMA - 1);
  localparam logic [BITS_CNT-1:0] N_GAN      = BITS_CNT'(BITS_GANANCIA);

  estado_t                    estado_q, estado_d;
  logic                       cs_q, cs_d;
  logic                       mosi_q, mosi_d;
  logic                       conv_q, conv_d;
  logic                       conv_fase_q, conv_fase_d;
  logic                       dv_q, dv_d;
  logic [BITS_SALIDA-1:0]     datos_q, datos_d;
  logic [BITS_MUESTRA-1:0]    muestra_q, muestra_d;
  logic [BITS_SALIDA-1:0]     muestra_red;

  logic                       gen_en, gen_clear, subida, bajada, cfg_activo, en_ventana;
  logic [BITS_CNT-1:0]        bit_cnt;
  logic [2:0]                 idx_mosi;

  generador_sck u_sck (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (gen_clear),
    .enable  (gen_en),
    .sck     (spi_sck),
    .subida  (subida),
    .bajada  (bajada),
    .bit_cnt (bit_cnt)
  );

  assign cfg_activo = (estado_q == AMP_CFG) && (bit_cnt < N_GAN);
  assign gen_en     = clock_enable && (cfg_activo || (estado_q == READ));
  assign gen_clear  = clock_enable &&
                      (((estado_q == AMP_CFG) && !cfg_activo) ||
                       ((estado_q == READ) && bajada && (bit_cnt == ULTIMO_BIT)));
  assign en_ventana = (bit_cnt >= INICIO) && (bit_cnt < FIN);
  // Next gain bit, loaded on the SCK fall so it is stable before the rise.
  assign idx_mosi   = 3'(BITS_GANANCIA - 2) - bit_cnt[2:0];

`ifdef ADC_REDONDEO_EN
  logic [BITS_SALIDA-1:0] suma;
  assign suma = muestra_q[BITS_MUESTRA-1:2] + BITS_SALIDA'(muestra_q[1]);
  // Only a positive sample can wrap into the sign bit.
  assign muestra_red = (!muestra_q[BITS_MUESTRA-1] && suma[BITS_SALIDA-1]) ? 12'h7FF : suma;
`else
  assign muestra_red = muestra_q[BITS_MUESTRA-1:2];
`endif

  // Next-state and output logic; everything advances only on clock_enable.
  always_comb begin
    estado_d    = estado_q;
    cs_d        = cs_q;
    mosi_d      = mosi_q;
    conv_d      = conv_q;
    conv_fase_d = conv_fase_q;
    datos_d     = datos_q;
    muestra_d   = muestra_q;
    dv_d        = 1'b0;
    case (estado_q)
      AMP_CFG: begin
        if (clock_enable) begin
          if (!cfg_activo) begin
            cs_d        = 1'b1;
            mosi_d      = 1'b0;
            conv_d      = 1'b1;
            conv_fase_d = 1'b0;
            estado_d    = CONV;
          end else begin
            cs_d = 1'b0;
            if (subida && (bit_cnt == '0))
              mosi_d = GANANCIA[BITS_GANANCIA-1];
            else if (bajada && (bit_cnt < N_GAN - 1'b1))
              mosi_d = GANANCIA[idx_mosi];
          end
        end
      end
      CONV: begin
        if (clock_enable) begin
          if (!conv_fase_q) begin
            conv_fase_d = 1'b1;
          end else begin
            conv_fase_d = 1'b0;
            conv_d      = 1'b0;
            estado_d    = READ;
          end
        end
      end
      READ: begin
        if (subida && en_ventana)
          muestra_d = {muestra_q[BITS_MUESTRA-2:0], spi_miso};
        if (bajada && (bit_cnt == ULTIMO_BIT))
          estado_d = PUBLISH;
      end
      PUBLISH: begin
        if (clock_enable) begin
          datos_d     = invertir_bits(muestra_red);
          dv_d        = 1'b1;
          conv_d      = 1'b1;
          conv_fase_d = 1'b0;
          estado_d    = CONV;
        end
      end
      default: estado_d = AMP_CFG;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= AMP_CFG;
      cs_q        <= 1'b1;
      mosi_q      <= 1'b0;
      conv_q      <= 1'b0;
      conv_fase_q <= 1'b0;
      dv_q        <= 1'b0;
      datos_q     <= '0;
      muestra_q   <= '0;
    end else begin
      estado_q    <= estado_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      conv_q      <= conv_d;
      conv_fase_q <= conv_fase_d;
      dv_q        <= dv_d;
      datos_q     <= datos_d;
      muestra_q   <= muestra_d;
    end
  end

  assign spi_mosi    = mosi_q;
  assign amp_cs      = cs_q;
  assign amp_shdn    = 1'b0;
  assign ad_conv     = conv_q;
  assign datos       = datos_q;
  assign dato_valido = dv_q;

endmodule
